// File: rtl/dsm_decimator_pkg.sv
// dsm_decimator_pkg: pwm code constants and defaults shared with the ternary modulator
package dsm_decimator_pkg;
  localparam logic [1:0] PWM_ZERO    = 2'b00;
  localparam logic [1:0] PWM_POS     = 2'b01;
  localparam logic [1:0] PWM_NEG     = 2'b11;
  localparam logic [1:0] PWM_ILLEGAL = 2'b10;
  localparam int DEC_R_LOG2 = 6;
  localparam int CIC_ORDER  = 3;
  function automatic logic signed [1:0] pwm_map(input logic [1:0] code);
    return (code == PWM_POS) ? 2'sb01 : (code == PWM_NEG) ? 2'sb11 : 2'sb00;
  endfunction
endpackage

// File: rtl/dsm_decimator_if.sv
// dsm_decimator_if: pwm code stream in, decimated samples and error flag out
interface dsm_decimator_if #(parameter int OUT_BITS = 11);
  logic [1:0] pwm_i;
  logic pwm_valid;
  logic signed [OUT_BITS-1:0] dout;
  logic dout_valid;
  logic err;
  modport master(output pwm_i, pwm_valid, input dout, dout_valid, err);
  modport slave(input pwm_i, pwm_valid, output dout, dout_valid, err);
endinterface

// File: rtl/dsm_decimator_comb.sv
// cic_comb_stage: one CIC comb section, dout = din - previous din captured on en
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);
  logic signed [W-1:0] d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) d <= '0;
    else if (en) d <= din;
  assign dout = din - d;
endmodule

// File: rtl/dsm_decimator.sv
// dsm_decimator: 3rd-order CIC decimator turning the ternary pwm stream into signed samples
module dsm_decimator
  import dsm_decimator_pkg::*;
#(
  parameter int R_LOG2   = DEC_R_LOG2,
  parameter int OUT_BITS = 11
) (
  input logic clock,
  input logic reset,
  dsm_decimator_if.slave bus
);
  localparam int ACC_BITS = 2 + CIC_ORDER * R_LOG2;
  localparam int SHIFT    = ACC_BITS - OUT_BITS;
  logic signed [1:0] m;
  logic signed [ACC_BITS-1:0] x, i1, i2, i3, c1, c2, c3;
  logic [R_LOG2-1:0] cnt;
  logic tick;
  assign m = pwm_map(bus.pwm_i);
  assign x = {{(ACC_BITS-2){m[1]}}, m};
  // integrators wrap modulo 2^ACC_BITS; the comb differences undo the wrap exactly
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
      cnt <= '0;
      tick <= 1'b0;
      bus.dout <= '0;
      bus.dout_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      if (bus.pwm_valid) begin
        i1 <= i1 + x;
        i2 <= i2 + i1;
        i3 <= i3 + i2;
        cnt <= cnt + R_LOG2'(1);
        if (bus.pwm_i == PWM_ILLEGAL) bus.err <= 1'b1;
      end
      tick <= bus.pwm_valid && (&cnt);
      bus.dout_valid <= tick;
      if (tick) bus.dout <= OUT_BITS'(c3 >>> SHIFT);
    end
  cic_comb_stage #(.W(ACC_BITS)) u_c1 (.clock(clock), .reset(reset), .en(tick), .din(i3), .dout(c1));
  cic_comb_stage #(.W(ACC_BITS)) u_c2 (.clock(clock), .reset(reset), .en(tick), .din(c1), .dout(c2));
  cic_comb_stage #(.W(ACC_BITS)) u_c3 (.clock(clock), .reset(reset), .en(tick), .din(c2), .dout(c3));
endmodule

// File: doc/dsm_decimator.md
Name: dsm_decimator

Overview:
- Receive-side counterpart of the DSM_top ternary modulator.
- Accepts the 3-level pwm code stream and converts it to a signed sample: 0 → 0, +1 → +VIN_FS_HALF, −1 → −VIN_FS_HALF.
- Filtering is a 3rd-order CIC decimator with R = 2^R_LOG2; output is one signed word per R accepted codes.
- Sits after the modulator in the loopback/monitor path and feeds bench scoreboards and the digital readback register.

Parameters:
- R_LOG2, 6: log2 of decimation ratio R (legal range 1..8).
- OUT_BITS, 11: output word width; equals T_BITS. Must be ≤ ACC_BITS.
- ACC_BITS, 2+3*R_LOG2 (derived, not overridable): integrator/comb width, 20 at default.
- SHIFT, ACC_BITS−OUT_BITS (derived): right shift applied to the comb result.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; logic held cleared while reset==0.
- pwm_i  in  2  modulator code: 2'b00 = 0, 2'b01 = +1, 2'b11 = −1, 2'b10 = illegal.
- pwm_valid  in  1  code qualifier; pwm_i is accepted on a rising edge only when this is high.
- dout  out  OUT_BITS  signed decimated sample; held between updates.
- dout_valid  out  1  one-cycle pulse when dout updates.
- err  out  1  sticky flag, set by any accepted 2'b10 code.

Behaviour:
- Async reset (reset==0) clears everything: integrators, comb delays, decimation counter, tick, dout=0, dout_valid=0, err=0. Reset mid-frame discards the partial frame with no output pulse. The first edge after release behaves as after power-up.
- Input mapping x: 00 → 0, 01 → +1, 11 → −1, 10 → 0 with err set on that edge. The mapped value is sign-extended to ACC_BITS.
- Integrators update on accepted edges only, all using pre-edge values:
  - i1 <= i1 + x
  - i2 <= i2 + i1
  - i3 <= i3 + i2
- Integrator arithmetic is modular ACC_BITS two's complement. Wrap-around is intentional: no saturation, no error flag.
- pwm_valid low: integrators and counter hold their values.
- Decimation counter cnt (R_LOG2 bits) increments on each accepted edge and wraps at R−1 → 0.
- When an accepted edge has cnt==R−1, the registered tick is asserted for the following cycle. tick is independent of pwm_valid in that cycle.
- Comb stage, active only on the tick cycle, combinational through all three stages and using pre-edge delay values:
  - c1 = i3 − d1
  - c2 = c1 − d2
  - c3 = c2 − d3
  - At the edge ending the tick cycle: d1<=i3, d2<=c1, d3<=c2, dout<=c3>>>SHIFT (arithmetic shift, floor), dout_valid<=1.
- All other cycles: dout_valid<=0; dout and the comb delays hold.
- Latency: dout_valid is high in the 2nd cycle after the edge that accepted the R-th code.
- Gain is R^3. Full-scale ±1 gives ±2^(3*R_LOG2), which maps to dout = ±2^(OUT_BITS−2) (±512 at default). No saturation is needed.
- Settling: the first 3 outputs after reset are transient. From the 4th output onward, a constant input gives the exact value.
- Back-to-back frames with pwm_valid held high: a new tick every R cycles; comb and integrator updates in the same cycle do not conflict.

Decomposition:
- Shared header parameters.vh gains:
  - pwm code constants PWM_ZERO, PWM_POS, PWM_NEG, PWM_ILLEGAL;
  - DEC_R_LOG2 default;
  - CIC_ORDER = 3.
  - Code constants are shared with DSM_top.
- One sub-module, cic_comb_stage:
  - parameter W;
  - inputs clock, reset, en, din[W-1:0];
  - outputs dout = din − d (combinational), internal delay d updated when en.
  - Instantiated three times.
- Integrators and the counter stay inline.

Test Plan:
- Constant 01 with pwm_valid=1, 5 frames (320 cycles) → outputs 4 and 5 equal +512; dout_valid is a single-cycle pulse 2 cycles after each 64th accepted code.
- Constant 11 → from the 4th output dout = −512. Constant 00 → every dout = 0, err = 0.
- Alternating 01/11 every cycle → from the 4th output dout = 0 exactly. Pattern 01,01,00,00 repeating → dout = +256.
- pwm_valid toggling 1/0 with constant 01 → dout_valid spacing 128 cycles; values identical to the gapless case (+512 from the 4th output).
- Single 10 code inside a stream of 00 → err rises on the cycle after acceptance and stays 1; outputs treat it as 0. Async reset pulse (reset=0 between edges) mid-frame → err, dout, dout_valid read 0 immediately, no pulse for the aborted frame, and the next output appears 64 accepted codes + 2 cycles after release.
- Constant 01 for 20000 cycles (integrator wrap exercised) → every output from the 4th onward stays exactly +512.
